// File: rtl/regfile_read_port.sv
// 8x16 register file with one write port, two registered read ports and a busy scoreboard.
// Optional write-through forwarding to the read ports when RFRD_BYPASS_EN is defined.
module regfile_read_port #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 write,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic                 rsv_en,
   input  logic [ADDR_W-1:0]    rsv_addr,
   input  logic                 stall,
   input  logic [ADDR_W-1:0]    rd_addr_a,
   input  logic [ADDR_W-1:0]    rd_addr_b,
   output logic [DATA_W-1:0]    rd_data_a,
   output logic [DATA_W-1:0]    rd_data_b,
   output logic                 rd_rdy_a,
   output logic                 rd_rdy_b,
   output logic [2**ADDR_W-1:0] busy_vec
);

   localparam int NREG = 2**ADDR_W;

   logic [DATA_W-1:0] regs_reg [NREG];
   logic              busy_reg [NREG];

   logic [DATA_W-1:0] data_a_next, data_b_next;
   logic              rdy_a_next, rdy_b_next;
   logic [DATA_W-1:0] data_a_reg, data_b_reg;
   logic              rdy_a_reg, rdy_b_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_entry
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               regs_reg[gi] <= '0;
            end else if (!write && wr_addr == ADDR_W'(gi)) begin
               regs_reg[gi] <= wr_data;
            end
         end

         // Reserve is checked first so it wins over a same-cycle clear.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               busy_reg[gi] <= 1'b0;
            end else if (rsv_en && rsv_addr == ADDR_W'(gi)) begin
               busy_reg[gi] <= 1'b1;
            end else if (!write && wr_addr == ADDR_W'(gi)) begin
               busy_reg[gi] <= 1'b0;
            end
         end

         assign busy_vec[gi] = busy_reg[gi];
      end
   endgenerate

   // Operands come from pre-edge state; a same-cycle reservation never affects them.
   always_comb begin
      data_a_next = regs_reg[rd_addr_a];
      rdy_a_next  = !busy_reg[rd_addr_a];
      data_b_next = regs_reg[rd_addr_b];
      rdy_b_next  = !busy_reg[rd_addr_b];
`ifdef RFRD_BYPASS_EN
      if (!write && wr_addr == rd_addr_a) begin
         data_a_next = wr_data;
         rdy_a_next  = 1'b1;
      end
      if (!write && wr_addr == rd_addr_b) begin
         data_b_next = wr_data;
         rdy_b_next  = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_a_reg <= '0;
         data_b_reg <= '0;
         rdy_a_reg  <= 1'b0;
         rdy_b_reg  <= 1'b0;
      end else if (!stall) begin
         data_a_reg <= data_a_next;
         data_b_reg <= data_b_next;
         rdy_a_reg  <= rdy_a_next;
         rdy_b_reg  <= rdy_b_next;
      end
   end

   assign rd_data_a = data_a_reg;
   assign rd_data_b = data_b_reg;
   assign rd_rdy_a  = rdy_a_reg;
   assign rd_rdy_b  = rdy_b_reg;

endmodule

// File: tb/tb_regfile_read_port.sv
// Randomized and directed bench for regfile_read_port against a behavioural model.
// Model follows RFRD_BYPASS_EN the same way the design build does.
module tb_regfile_read_port;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        write = 1'b1;
   logic [2:0]  wr_addr = '0;
   logic [15:0] wr_data = '0;
   logic        rsv_en = 1'b0;
   logic [2:0]  rsv_addr = '0;
   logic        stall = 1'b0;
   logic [2:0]  rd_addr_a = '0;
   logic [2:0]  rd_addr_b = '0;
   logic [15:0] rd_data_a, rd_data_b;
   logic        rd_rdy_a, rd_rdy_b;
   logic [7:0]  busy_vec;

   int vectors = 0;
   int miscompares = 0;
   bit check_en = 1'b0;

   regfile_read_port dut (
      .clk(clk), .reset(reset), .write(write), .wr_addr(wr_addr), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .stall(stall),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .rd_rdy_a(rd_rdy_a), .rd_rdy_b(rd_rdy_b), .busy_vec(busy_vec)
   );

   always #5 clk = ~clk;

   // Behavioural model: register contents, busy set, and the operand latches.
   logic [15:0] m_regs [8];
   logic [7:0]  m_busy = '0;
   logic [15:0] m_data_a = '0, m_data_b = '0;
   logic        m_rdy_a = 1'b0, m_rdy_b = 1'b0;

   initial for (int i = 0; i < 8; i++) m_regs[i] = '0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) m_regs[i] = '0;
         m_busy = '0;
         m_data_a = '0; m_data_b = '0;
         m_rdy_a = 1'b0; m_rdy_b = 1'b0;
      end else begin
         if (!stall) begin
            m_data_a = m_regs[rd_addr_a];
            m_rdy_a  = !m_busy[rd_addr_a];
            m_data_b = m_regs[rd_addr_b];
            m_rdy_b  = !m_busy[rd_addr_b];
`ifdef RFRD_BYPASS_EN
            if (!write && wr_addr == rd_addr_a) begin m_data_a = wr_data; m_rdy_a = 1'b1; end
            if (!write && wr_addr == rd_addr_b) begin m_data_b = wr_data; m_rdy_b = 1'b1; end
`endif
         end
         if (!write) begin
            m_regs[wr_addr] = wr_data;
            m_busy[wr_addr] = 1'b0;
         end
         if (rsv_en) m_busy[rsv_addr] = 1'b1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         chk("model_rd_data_a", 32'(rd_data_a), 32'(m_data_a));
         chk("model_rd_data_b", 32'(rd_data_b), 32'(m_data_b));
         chk("model_rd_rdy_a",  32'(rd_rdy_a),  32'(m_rdy_a));
         chk("model_rd_rdy_b",  32'(rd_rdy_b),  32'(m_rdy_b));
         chk("model_busy_vec",  32'(busy_vec),  32'(m_busy));
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      write = 1'b1; rsv_en = 1'b0; stall = 1'b0;
   endtask

   task automatic do_write(input logic [2:0] a, input logic [15:0] d);
      write = 1'b0; wr_addr = a; wr_data = d;
   endtask

   initial begin
      // 1. reset state, then read R3 after release
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_data_a", 32'(rd_data_a), 32'h0);
      chk("reset_busy", 32'(busy_vec), 32'h0);
      reset = 1'b0;
      rd_addr_a = 3'd3;
      check_en = 1'b1;
      step();
      chk("r3_after_reset_data", 32'(rd_data_a), 32'h0000);
      chk("r3_after_reset_rdy", 32'(rd_rdy_a), 32'h1);

      // 2. basic write/read on both ports
      do_write(3'd5, 16'hBEEF);
      step();
      idle();
      rd_addr_a = 3'd5; rd_addr_b = 3'd5;
      step();
      chk("beef_a", 32'(rd_data_a), 32'hBEEF);
      chk("beef_b", 32'(rd_data_b), 32'hBEEF);
      chk("beef_rdy_a", 32'(rd_rdy_a), 32'h1);
      chk("beef_rdy_b", 32'(rd_rdy_b), 32'h1);

      // 3. scoreboard set and clear
      rsv_en = 1'b1; rsv_addr = 3'd2;
      step();
      idle();
      chk("busy_r2", 32'(busy_vec), 32'h04);
      rd_addr_a = 3'd2;
      step();
      chk("r2_not_ready", 32'(rd_rdy_a), 32'h0);
      do_write(3'd2, 16'h1234);
      step();
      idle();
      chk("busy_cleared", 32'(busy_vec), 32'h00);
      step();
      chk("r2_data", 32'(rd_data_a), 32'h1234);
      chk("r2_ready", 32'(rd_rdy_a), 32'h1);

      // 4. reserve wins over same-cycle clear
      rsv_en = 1'b1; rsv_addr = 3'd4;
      step();
      do_write(3'd4, 16'h4444);
      rsv_en = 1'b1; rsv_addr = 3'd4;
      step();
      idle();
      chk("collision_busy4", 32'(busy_vec[4]), 32'h1);
      rd_addr_a = 3'd4;
      step();
      chk("collision_data", 32'(rd_data_a), 32'h4444);
      chk("collision_rdy", 32'(rd_rdy_a), 32'h0);

      // 5. stall hold
      do_write(3'd1, 16'h0011);
      step();
      idle();
      rd_addr_a = 3'd1;
      step();
      chk("stall_pre", 32'(rd_data_a), 32'h0011);
      stall = 1'b1; rd_addr_a = 3'd6;
      do_write(3'd1, 16'h0022);
      step();
      chk("stall_hold1", 32'(rd_data_a), 32'h0011);
      do_write(3'd6, 16'h6666);
      step();
      chk("stall_hold2", 32'(rd_data_a), 32'h0011);
      write = 1'b1;
      step();
      chk("stall_hold3", 32'(rd_data_a), 32'h0011);
      stall = 1'b0;
      step();
      chk("stall_release_r6", 32'(rd_data_a), 32'h6666);

      // 6. same-cycle write/read of a busy register
      do_write(3'd7, 16'h0001);
      step();
      idle();
      rsv_en = 1'b1; rsv_addr = 3'd7;
      step();
      idle();
      do_write(3'd7, 16'hCAFE);
      rd_addr_a = 3'd7;
      step();
      idle();
`ifdef RFRD_BYPASS_EN
      chk("same_cycle_data", 32'(rd_data_a), 32'hCAFE);
      chk("same_cycle_rdy", 32'(rd_rdy_a), 32'h1);
`else
      chk("same_cycle_data", 32'(rd_data_a), 32'h0001);
      chk("same_cycle_rdy", 32'(rd_rdy_a), 32'h0);
`endif
      step();
      chk("after_same_cycle_data", 32'(rd_data_a), 32'hCAFE);
      chk("after_same_cycle_rdy", 32'(rd_rdy_a), 32'h1);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         write     = 1'($urandom_range(0, 1));
         wr_addr   = 3'($urandom_range(0, 7));
         wr_data   = 16'($urandom);
         rsv_en    = ($urandom_range(0, 2) == 0);
         rsv_addr  = 3'($urandom_range(0, 7));
         stall     = ($urandom_range(0, 4) == 0);
         rd_addr_a = 3'($urandom_range(0, 7));
         rd_addr_b = 3'($urandom_range(0, 7));
         step();
      end

      // mid-cycle asynchronous reset with live state
      idle();
      rsv_en = 1'b1; rsv_addr = 3'd3;
      do_write(3'd0, 16'hA5A5);
      rd_addr_a = 3'd7; rd_addr_b = 3'd0;
      step();
      idle();
      step();
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_data_a", 32'(rd_data_a), 32'h0);
      chk("async_reset_data_b", 32'(rd_data_b), 32'h0);
      chk("async_reset_rdy_a", 32'(rd_rdy_a), 32'h0);
      chk("async_reset_rdy_b", 32'(rd_rdy_b), 32'h0);
      chk("async_reset_busy", 32'(busy_vec), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      rd_addr_a = 3'd0;
      step();
      chk("post_reset_r0", 32'(rd_data_a), 32'h0);
      chk("post_reset_r0_rdy", 32'(rd_rdy_a), 32'h1);

      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile_read_port.md
Name: regfile_read_port

Overview:
- Read-side companion to the single-register write path.
- 8 x 16 register file with one write port, two registered read ports and a per-register busy scoreboard.
- Sits between decode and execute. Operands are sampled from decode addresses and presented one cycle later, with a ready flag per operand.
- The ready flag tells hazard logic whether a write to that register is still outstanding.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, register address width; the file holds 2**ADDR_W entries.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- write  input  1  active-low write enable for the write port.
- wr_addr  input  ADDR_W  destination register for the write port.
- wr_data  input  DATA_W  write data.
- rsv_en  input  1  active-high; marks rsv_addr busy (pending write issued).
- rsv_addr  input  ADDR_W  register being reserved.
- stall  input  1  active-high; holds read outputs.
- rd_addr_a  input  ADDR_W  read port A address.
- rd_addr_b  input  ADDR_W  read port B address.
- rd_data_a  output  DATA_W  registered operand A.
- rd_data_b  output  DATA_W  registered operand B.
- rd_rdy_a  output  1  operand A is valid (no outstanding write).
- rd_rdy_b  output  1  operand B is valid.
- busy_vec  output  2**ADDR_W  current scoreboard bits, bit i = register i busy.

Behaviour:
Reset:
- reset=1 asynchronously clears all 8 registers and busy_vec to 0.
- rd_data_a/b and rd_rdy_a/b also clear to 0.
- This holds regardless of clk, including mid-stall or mid-write.
- First posedge after reset deasserts refreshes the outputs.

Write:
- At posedge with write=0: regs[wr_addr] <= wr_data.
- write=1: no change.

Scoreboard, per posedge, applied in this order:
1. If write=0, clear busy[wr_addr].
2. If rsv_en=1, set busy[rsv_addr].
- When both target the same address, reserve wins and the bit ends at 1.
- Reserving an already-busy register leaves it busy (no counting).

Read:
- At posedge with stall=0:
  - rd_data_x <= regs[rd_addr_x]
  - rd_rdy_x <= !busy[rd_addr_x]
  - Both use pre-edge state.
- Latency: address at edge N gives data after edge N+1.
- At posedge with stall=1: rd_data_a/b and rd_rdy_a/b hold.
- Writes and scoreboard updates continue normally during stall.
- A reservation made in the same cycle never affects the ready flag computed in that cycle. The reserving instruction is younger than the reader.
- Ports A and B are independent. Both may read the same address and return identical results.

Simultaneous write and read of the same address, without bypass:
- Read returns the old value.
- rdy reflects the pre-clear busy bit.

busy_vec is the registered scoreboard state and is visible directly.

Optional Feature:
Macro: RFRD_BYPASS_EN.
- Defined:
  - If write=0 and wr_addr==rd_addr_x at the sampling edge (stall=0), then rd_data_x <= wr_data and rd_rdy_x <= 1.
  - This write-through forwarding applies to each port independently.
  - The forwarded value is the one written in that cycle.
  - The stall hold rule is unchanged.
- Undefined:
  - No forwarding.
  - Same-cycle write/read returns the old contents and pre-clear ready, as in Behaviour.
- Storage, scoreboard and reset are identical in both builds.

Test Plan:
1. Reset check:
   - Stimulus: assert reset between clock edges.
   - Response: immediately all outputs 0 and busy_vec=8'h00.
   - Stimulus: release reset, read R3 on port A.
   - Response: rd_data_a=16'h0000, rd_rdy_a=1.
2. Basic write/read:
   - Stimulus: write=0, wr_addr=5, wr_data=16'hBEEF. Next cycle set rd_addr_a=5, rd_addr_b=5.
   - Response: one edge later rd_data_a=rd_data_b=16'hBEEF, both rdy=1.
3. Scoreboard:
   - Stimulus: rsv_en=1, rsv_addr=2.
   - Response: next cycle busy_vec=8'h04; read R2 gives rd_rdy_a=0.
   - Stimulus: write=0 to R2 with 16'h1234.
   - Response: busy_vec=8'h00 after the edge; subsequent read gives 16'h1234, rdy=1.
4. Reserve-vs-clear collision:
   - Stimulus: R4 busy; same cycle write=0 wr_addr=4 and rsv_en=1 rsv_addr=4.
   - Response: busy_vec bit4 stays 1; R4 holds the new write data.
5. Stall hold:
   - Stimulus: read R1=16'h0011 on A; raise stall for 3 cycles while rd_addr_a changes to 6 and R1 is rewritten to 16'h0022.
   - Response: rd_data_a stays 16'h0011 until stall drops. On the first edge with stall=0, R6 is sampled.
6. Same-cycle write/read of R7 with 16'hCAFE, old value 16'h0001, R7 busy:
   - Response with RFRD_BYPASS_EN defined: rd_data_a=16'hCAFE, rdy=1.
   - Response with it undefined: rd_data_a=16'h0001, rdy=0; the next read returns 16'hCAFE with rdy=1.
